mux2_arb: RTL and testbench
===========================

MUX2_ARB -- requirements
Module: mux2_arb

Interface
REQ-001 Parameter DATA_W, default 2, SHALL set the width of each data path.
REQ-002 Parameter MAX_HOLD, default 8, legal range 2..255, SHALL set the maximum consecutive grant cycles under contention.
REQ-003 sys_clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 sys_rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 req1  in  1  SHALL be the requester-1 request, level-held while the requester wants the path.
REQ-006 req2  in  1  SHALL be the requester-2 request, level-held.
REQ-007 in1  in  DATA_W  SHALL be the requester-1 data.
REQ-008 in2  in  DATA_W  SHALL be the requester-2 data.
REQ-009 gnt1  out  1  SHALL be the registered grant to requester 1.
REQ-010 gnt2  out  1  SHALL be the registered grant to requester 2.
REQ-011 sel  out  1  SHALL be the mux select: 1 selects in1, 0 selects in2.
REQ-012 out  out  DATA_W  SHALL be the registered shared-path data.
REQ-013 out_vld  out  1  SHALL mark out as carrying granted data.
REQ-014 busy  out  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, GNT1, GNT2; gnt1 = (state==GNT1), gnt2 = (state==GNT2), sel = gnt1.
REQ-016 In IDLE with only reqN high, the FSM SHALL enter GNTN on the next edge.
REQ-017 In IDLE with req1 and req2 both high, the FSM SHALL grant the requester not recorded in last_gnt; last_gnt SHALL reset to 2, so requester 1 wins first.
REQ-018 last_gnt SHALL update to N on every entry into GNTN.
REQ-019 In GNTN with reqN low, the FSM SHALL move directly to the other grant state if the other request is high, otherwise to IDLE; there SHALL be no idle gap.
REQ-020 hold_cnt SHALL clear on every grant-state entry and increment on each cycle spent in a grant state.
REQ-021 In GNTN with reqN high, the other request high and hold_cnt == MAX_HOLD-1, the FSM SHALL pre-empt to the other grant state.
REQ-022 In GNTN with reqN high and the other request low, hold_cnt SHALL saturate at MAX_HOLD-1 and the grant SHALL persist.
REQ-023 out SHALL register the sel-selected input one edge after a cycle in which (gnt1&req1) or (gnt2&req2) holds.
REQ-024 out_vld SHALL be high in exactly those cycles.
REQ-025 When out_vld is low, out SHALL hold its last value.
REQ-026 Latency SHALL be: req sampled at edge k -> grant high after edge k -> out_vld high with data after edge k+1.
REQ-027 At most one of gnt1 and gnt2 SHALL be high in any cycle.

Reset
REQ-028 On sys_rst_n low, the block SHALL immediately force state=IDLE, gnt1=gnt2=sel=0, out=0, out_vld=0, busy=0, hold_cnt=0 and last_gnt=2, independent of sys_clk.
REQ-029 Reset asserted mid-grant SHALL abort the grant; after release, arbitration SHALL restart from IDLE with requester 1 preferred.

Structure
REQ-030 Package mux2_arb_pkg SHALL hold the state encoding (IDLE=2'd0, GNT1=2'd1, GNT2=2'd2) and the MAX_HOLD and DATA_W defaults.
REQ-031 The data path SHALL be one instance of the existing mux2_1, driven by sel, with its output registered in mux2_arb.

Verification (DATA_W=2, MAX_HOLD=4)
REQ-032 Reset release, req1=1, in1=2'b10, req2=0 -> gnt1=1 after edge 1; out=2'b10 with out_vld=1 after edge 2.
REQ-033 req1=req2=1 from IDLE -> GNT1 for 4 cycles, then GNT2 for 4 cycles, alternating, with no IDLE cycle.
REQ-034 req2 alone held 10 cycles -> gnt2 continuous for 10 cycles; hold_cnt saturates at 3 with no pre-emption.
REQ-035 In GNT1, drop req1 while req2=1 -> gnt2=1 on the next edge and gnt1 never overlaps gnt2.
REQ-036 Assert sys_rst_n=0 mid-GNT2 -> all outputs 0 immediately; after release with both requests high -> gnt1 granted first.
REQ-037 Random req and data for 2000 cycles -> scoreboard confirms grant exclusivity, out equals the granted input delayed 1 cycle, and no grant lasts more than 4 cycles under contention.

Source files
------------

// File: rtl/mux2_arb_pkg.sv
// Shared definitions for the two-requester arbiter.
//   arb_state_e   : FSM state encoding (IDLE / GNT1 / GNT2)
//   DATA_W_DEF    : default data-path width
//   MAX_HOLD_DEF  : default maximum consecutive grant cycles under contention
//   HOLD_W        : hold counter width (covers MAX_HOLD up to 255)
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } arb_state_e;

    localparam int DATA_W_DEF   = 2;
    localparam int MAX_HOLD_DEF = 8;
    localparam int HOLD_W       = 8;

endpackage

// File: rtl/mux2_1.sv
// Plain 2:1 multiplexer.
//   in0, in1 : data inputs
//   sel      : 1 selects in1, 0 selects in0
//   y        : selected data (combinational)
module mux2_1 #(
    parameter int W = 2
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         sel,
    output logic [W-1:0] y
);

    assign y = sel ? in1 : in0;

endmodule

// File: rtl/mux2_arb.sv
// Two-requester arbiter driving a shared, registered data path.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   req1, req2         : level-held requests
//   in1, in2           : requester data
//   gnt1, gnt2         : registered grants (one-hot or none)
//   sel                : mux select, 1 = in1
//   out, out_vld       : registered shared-path data and its qualifier
//   busy               : FSM not in IDLE
//
// state | meaning
// IDLE  | no grant outstanding
// GNT1  | requester 1 owns the path
// GNT2  | requester 2 owns the path
module mux2_arb
    import mux2_arb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              req1,
    input  logic              req2,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic              gnt1,
    output logic              gnt2,
    output logic              sel,
    output logic [DATA_W-1:0] out,
    output logic              out_vld,
    output logic              busy
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e        state_q, state_d;
    logic              last2_q, last2_d;   // 1: requester 2 was granted last
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] mux_y;

    assign gnt1    = (state_q == GNT1);
    assign gnt2    = (state_q == GNT2);
    assign sel     = gnt1;
    assign busy    = (state_q != IDLE);
    assign out     = out_q;
    assign out_vld = out_vld_q;

    mux2_1 #(.W(DATA_W)) u_mux (
        .in0 (in2),
        .in1 (in1),
        .sel (sel),
        .y   (mux_y)
    );

    always_comb begin
        state_d    = state_q;
        last2_d    = last2_q;
        hold_cnt_d = hold_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req1 && req2)  state_d = last2_q ? GNT1 : GNT2;
                else if (req1)     state_d = GNT1;
                else if (req2)     state_d = GNT2;
            end
            GNT1: begin
                if (!req1)                            state_d = req2 ? GNT2 : IDLE;
                else if (req2 && hold_cnt_q == HOLD_LAST) state_d = GNT2;
            end
            GNT2: begin
                if (!req2)                            state_d = req1 ? GNT1 : IDLE;
                else if (req1 && hold_cnt_q == HOLD_LAST) state_d = GNT1;
            end
            default: state_d = IDLE;
        endcase

        // Counter restarts on any state change and saturates while a lone owner holds.
        if (state_d != state_q) begin
            hold_cnt_d = '0;
            if (state_d == GNT1) last2_d = 1'b0;
            if (state_d == GNT2) last2_d = 1'b1;
        end else if (state_q != IDLE && hold_cnt_q != HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_comb begin
        out_vld_d = (gnt1 & req1) | (gnt2 & req2);
        out_d     = out_vld_d ? mux_y : out_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            last2_q    <= 1'b1;
            hold_cnt_q <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last2_q    <= last2_d;
            hold_cnt_q <= hold_cnt_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
        end
    end

endmodule

// File: tb/tb_mux2_arb.sv
module tb_mux2_arb;

    localparam int DW = 2;
    localparam int MH = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          req1 = 1'b0, req2 = 1'b0;
    logic [DW-1:0] in1 = '0, in2 = '0;
    logic          gnt1, gnt2, sel, out_vld, busy;
    logic [DW-1:0] out;

    int n_chk  = 0;
    int n_pass = 0;

    mux2_arb #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req1      (req1),
        .req2      (req2),
        .in1       (in1),
        .in2       (in2),
        .gnt1      (gnt1),
        .gnt2      (gnt2),
        .sel       (sel),
        .out       (out),
        .out_vld   (out_vld),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        req1 = 1'b0; req2 = 1'b0; in1 = '0; in2 = '0;
        repeat (2) @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b1;
    endtask

    typedef struct {
        logic          r1, r2;
        logic [DW-1:0] i1, i2;
        logic          g1, g2, vld;
        logic [DW-1:0] o;
    } vec_t;

    vec_t vecs[9];

    // reference model state for the random phase
    int            m_owner;   // 0 none, 1, 2
    int            m_run;     // cycles the current owner has held the path
    int            m_pref;    // winner of the next simultaneous request from IDLE
    logic [DW-1:0] m_out;
    int            c_run;     // consecutive cycles held while the other side was waiting

    initial begin
        //            r1    r2    i1     i2     g1    g2    vld   out
        vecs[0] = '{1'b1, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[1] = '{1'b1, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2};
        vecs[2] = '{1'b0, 1'b1, 2'd3, 2'd1, 1'b0, 1'b1, 1'b0, 2'd2};
        vecs[3] = '{1'b0, 1'b1, 2'd3, 2'd1, 1'b0, 1'b1, 1'b1, 2'd1};
        vecs[4] = '{1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[5] = '{1'b1, 1'b1, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 2'd1};
        vecs[6] = '{1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[7] = '{1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 2'd1};
        vecs[8] = '{1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 1'b1, 1'b1, 2'd2};

        // reset values
        #2;
        chk("rst_gnt1", gnt1, 0);
        chk("rst_gnt2", gnt2, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vld", out_vld, 0);
        do_reset();

        // table-driven sequence from reset
        for (int i = 0; i < 9; i++) begin
            req1 = vecs[i].r1; req2 = vecs[i].r2;
            in1 = vecs[i].i1;  in2 = vecs[i].i2;
            tick();
            chk($sformatf("vec%0d_gnt1", i), gnt1, vecs[i].g1);
            chk($sformatf("vec%0d_gnt2", i), gnt2, vecs[i].g2);
            chk($sformatf("vec%0d_vld", i), out_vld, vecs[i].vld);
            chk($sformatf("vec%0d_out", i), out, vecs[i].o);
        end

        // contention alternates in blocks of MAX_HOLD, no idle cycle
        do_reset();
        req1 = 1'b1; req2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("alt%0d_gnt1", i), gnt1, ((i / MH) % 2 == 0) ? 1 : 0);
            chk($sformatf("alt%0d_gnt2", i), gnt2, ((i / MH) % 2 == 1) ? 1 : 0);
            chk($sformatf("alt%0d_busy", i), busy, 1);
        end

        // lone requester keeps the grant, counter saturates
        do_reset();
        req2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("solo%0d_gnt2", i), gnt2, 1);
        end
        chk("solo_hold_cnt", int'(dut.hold_cnt_q), MH - 1);

        // handover without gap or overlap
        do_reset();
        req1 = 1'b1;
        tick();
        chk("hand_gnt1", gnt1, 1);
        req1 = 1'b0; req2 = 1'b1;
        tick();
        chk("hand_gnt2", gnt2, 1);
        chk("hand_gnt1_off", gnt1, 0);

        // reset during GNT2
        do_reset();
        req2 = 1'b1; in2 = 2'd3;
        tick();
        tick();
        chk("pre_rst_vld", out_vld, 1);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_gnt2", gnt2, 0);
        chk("midrst_sel", sel, 0);
        chk("midrst_vld", out_vld, 0);
        chk("midrst_out", out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_hold", int'(dut.hold_cnt_q), 0);
        req1 = 1'b1; req2 = 1'b1;
        #1;
        sys_rst_n = 1'b1;
        tick();
        chk("postrst_gnt1", gnt1, 1);
        chk("postrst_gnt2", gnt2, 0);

        // randomized run against the reference model
        do_reset();
        m_owner = 0; m_run = 0; m_pref = 1; m_out = '0; c_run = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int   mine, other, nxt, other_id;
            logic exp_vld, prev_other;
            req1 = ($urandom_range(0, 3) != 0);
            req2 = ($urandom_range(0, 3) != 0);
            in1  = DW'($urandom);
            in2  = DW'($urandom);

            exp_vld = (m_owner == 1 && req1) || (m_owner == 2 && req2);
            if (exp_vld) m_out = (m_owner == 1) ? in1 : in2;

            mine     = (m_owner == 1) ? int'(req1) : int'(req2);
            other    = (m_owner == 1) ? int'(req2) : int'(req1);
            other_id = 3 - m_owner;
            if (m_owner == 0)
                nxt = (req1 && req2) ? m_pref : (req1 ? 1 : (req2 ? 2 : 0));
            else if (!mine)
                nxt = other ? other_id : 0;
            else if (other && m_run >= MH)
                nxt = other_id;
            else
                nxt = m_owner;

            prev_other = (m_owner != 0) && (other != 0);
            if (nxt != m_owner && nxt != 0) begin
                m_run = 1;
                m_pref = 3 - nxt;
                c_run = 1;
            end else if (nxt != 0) begin
                if (m_run < MH) m_run++;
                c_run = prev_other ? c_run + 1 : 1;
            end else begin
                m_run = 0;
                c_run = 0;
            end
            m_owner = nxt;

            tick();
            chk("rnd_gnt1", gnt1, (m_owner == 1) ? 1 : 0);
            chk("rnd_gnt2", gnt2, (m_owner == 2) ? 1 : 0);
            chk("rnd_sel", sel, (m_owner == 1) ? 1 : 0);
            chk("rnd_busy", busy, (m_owner != 0) ? 1 : 0);
            chk("rnd_excl", int'(gnt1 & gnt2), 0);
            chk("rnd_vld", out_vld, int'(exp_vld));
            chk("rnd_out", out, m_out);
            chk("rnd_contention_run_ok", int'(c_run <= MH), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
